// File: rtl/alu_pkg.sv
// Shared definitions for the LR35902 accumulator ALU: op encodings and flag bit positions.
package alu_pkg;

  typedef enum logic [2:0] {
    OpAdd = 3'd0,
    OpAdc = 3'd1,
    OpSub = 3'd2,
    OpSbc = 3'd3,
    OpAnd = 3'd4,
    OpXor = 3'd5,
    OpOr  = 3'd6,
    OpCp  = 3'd7
  } alu_op_e;

  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_H = 1;
  localparam int unsigned FLAG_C = 0;

endpackage

// File: rtl/alu_addsub.sv
// Combinational 8-bit adder/subtractor with carry-in; reports carry/borrow out of bit 7 and bit 3.
module alu_addsub (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       c_i,
  input  logic       sub_i,
  output logic [7:0] res_o,
  output logic       c_o,
  output logic       h_o
);

  logic [8:0] full;
  logic [4:0] half;

  // Widened by one bit so the MSB is the carry (add) or the sign of the difference (borrow, sub).
  always_comb begin
    if (sub_i) begin
      full = {1'b0, a_i} - {1'b0, b_i} - {8'b0, c_i};
      half = {1'b0, a_i[3:0]} - {1'b0, b_i[3:0]} - {4'b0, c_i};
    end else begin
      full = {1'b0, a_i} + {1'b0, b_i} + {8'b0, c_i};
      half = {1'b0, a_i[3:0]} + {1'b0, b_i[3:0]} + {4'b0, c_i};
    end
  end

  assign res_o = full[7:0];
  assign c_o   = full[8];
  assign h_o   = half[4];

endmodule

// File: rtl/alu_mod.sv
// LR35902 accumulator ALU with registered result and Z/N/H/C flags.
// Define ALU_AND_HSET_EN to make AND set H=1 as on the real CPU.
module alu_mod
  import alu_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] in_A,
  input  logic [7:0] in_B,
  input  logic [2:0] alu_op,
  input  logic       in_C,
  output logic [7:0] out,
  output logic [3:0] out_flags
);

`ifdef ALU_AND_HSET_EN
  localparam logic AndHFlag = 1'b1;
`else
  localparam logic AndHFlag = 1'b0;
`endif

  alu_op_e    op;
  logic       is_sub;
  logic       cin;
  logic [7:0] as_res;
  logic       as_c;
  logic       as_h;

  assign op     = alu_op_e'(alu_op);
  assign is_sub = (op == OpSub) || (op == OpSbc) || (op == OpCp);
  assign cin    = ((op == OpAdc) || (op == OpSbc)) ? in_C : 1'b0;

  alu_addsub u_addsub (
    .a_i   (in_A),
    .b_i   (in_B),
    .c_i   (cin),
    .sub_i (is_sub),
    .res_o (as_res),
    .c_o   (as_c),
    .h_o   (as_h)
  );

  logic [7:0] res_d, res_q;
  logic [3:0] flags_d, flags_q;
  logic [7:0] zsrc;
  logic       c_d;
  logic       h_d;

  always_comb begin
    res_d   = as_res;
    zsrc    = as_res;
    c_d     = as_c;
    h_d     = as_h;
    flags_d = 4'h0;
    unique case (op)
      OpAnd: begin
        res_d = in_A & in_B;
        zsrc  = res_d;
        c_d   = 1'b0;
        h_d   = AndHFlag;
      end
      OpXor: begin
        res_d = in_A ^ in_B;
        zsrc  = res_d;
        c_d   = 1'b0;
        h_d   = 1'b0;
      end
      OpOr: begin
        res_d = in_A | in_B;
        zsrc  = res_d;
        c_d   = 1'b0;
        h_d   = 1'b0;
      end
      // CP leaves A intact; Z still reflects the difference.
      OpCp:    res_d = in_A;
      default: ;
    endcase
    flags_d[FLAG_Z] = (zsrc == 8'h00);
    flags_d[FLAG_N] = is_sub;
    flags_d[FLAG_H] = h_d;
    flags_d[FLAG_C] = c_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      res_q   <= 8'h00;
      flags_q <= 4'h0;
    end else begin
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign out       = res_q;
  assign out_flags = flags_q;

endmodule

// File: tb/tb_alu_mod.sv
// Self-checking bench for alu_mod: directed vectors, random ops and asynchronous reset behaviour.
module tb_alu_mod;

  logic       clock;
  logic       reset_n;
  logic [7:0] in_A;
  logic [7:0] in_B;
  logic [2:0] alu_op;
  logic       in_C;
  logic [7:0] out;
  logic [3:0] out_flags;

  int n_pass  = 0;
  int n_total = 0;

  alu_mod dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_A      (in_A),
    .in_B      (in_B),
    .alu_op    (alu_op),
    .in_C      (in_C),
    .out       (out),
    .out_flags (out_flags)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: {out, Z, N, H, C} from integer arithmetic on the op definitions.
  function automatic logic [11:0] model(input int op, input int a, input int b, input int c);
    int r;
    int res;
    int z, n, h, cy;
    int and_h;
`ifdef ALU_AND_HSET_EN
    and_h = 1;
`else
    and_h = 0;
`endif
    n = 0; h = 0; cy = 0; r = 0; res = 0;
    case (op)
      0: begin r = a + b;     cy = (r > 255) ? 1 : 0; h = ((a % 16) + (b % 16) > 15) ? 1 : 0; end
      1: begin r = a + b + c; cy = (r > 255) ? 1 : 0; h = ((a % 16) + (b % 16) + c > 15) ? 1 : 0; end
      2, 7: begin r = a - b; n = 1; cy = (a < b) ? 1 : 0; h = ((a % 16) < (b % 16)) ? 1 : 0; end
      3: begin r = a - b - c; n = 1; cy = (a < b + c) ? 1 : 0;
               h = ((a % 16) < (b % 16) + c) ? 1 : 0; end
      4: begin r = a & b; h = and_h; end
      5: r = a ^ b;
      default: r = a | b;
    endcase
    res = (r + 512) % 256;
    z = (res == 0) ? 1 : 0;
    if (op == 7) res = a;
    return {8'(res), 1'(z), 1'(n), 1'(h), 1'(cy)};
  endfunction

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%03h expected=%03h", tag, obs, exp);
  endtask

  // Drive at negedge, sample 1 time unit after the capturing rising edge.
  task automatic do_op(input string tag, input int op, input int a, input int b, input int c);
    @(negedge clock);
    alu_op = 3'(op);
    in_A   = 8'(a);
    in_B   = 8'(b);
    in_C   = 1'(c);
    @(posedge clock);
    #1;
    check(tag, {out, out_flags}, model(op, a, b, c));
  endtask

  initial begin
    reset_n = 1'b0;
    in_A = 8'h00; in_B = 8'h00; alu_op = 3'd0; in_C = 1'b0;
    #1;
    check("reset_initial", {out, out_flags}, 12'h000);
    #12;
    reset_n = 1'b1;

    do_op("add_04_0f", 0, 8'h04, 8'h0F, 0);
    check("add_04_0f_const", {out, out_flags}, {8'h13, 4'b0010});
    do_op("add_04_fc", 0, 8'h04, 8'hFC, 0);
    check("add_04_fc_const", {out, out_flags}, {8'h00, 4'b1011});
    do_op("add_30_f0", 0, 8'h30, 8'hF0, 0);
    do_op("add_ff_01", 0, 8'hFF, 8'h01, 1);
    do_op("adc_04_05", 1, 8'h04, 8'h05, 1);
    do_op("adc_30_cf", 1, 8'h30, 8'hCF, 1);
    do_op("adc_00_ff", 1, 8'h00, 8'hFF, 1);
    check("adc_00_ff_const", {out, out_flags}, {8'h00, 4'b1011});
    do_op("sub_23_04", 2, 8'h23, 8'h04, 1);
    do_op("sub_23_23", 2, 8'h23, 8'h23, 0);
    do_op("sub_23_24", 2, 8'h23, 8'h24, 0);
    check("sub_23_24_const", {out, out_flags}, {8'hFF, 4'b0111});
    do_op("sub_00_01", 2, 8'h00, 8'h01, 0);
    do_op("sbc_00_00", 3, 8'h00, 8'h00, 1);
    check("sbc_00_00_const", {out, out_flags}, {8'hFF, 4'b0111});
    do_op("sbc_10_0f", 3, 8'h10, 8'h0F, 1);
    do_op("and_5c_0f", 4, 8'h5C, 8'h0F, 1);
    do_op("xor_5c_ff", 5, 8'h5C, 8'hFF, 1);
    check("xor_5c_ff_const", {out, out_flags}, {8'hA3, 4'b0000});
    do_op("or_5c_f0",  6, 8'h5C, 8'hF0, 0);
    do_op("and_5c_00", 4, 8'h5C, 8'h00, 0);
    do_op("cp_23_24",  7, 8'h23, 8'h24, 1);
    check("cp_23_24_const", {out, out_flags}, {8'h23, 4'b0111});
    do_op("cp_23_23",  7, 8'h23, 8'h23, 0);
    check("cp_23_23_const", {out, out_flags}, {8'h23, 4'b1100});

    for (int i = 0; i < 300; i++) begin
      do_op("random", int'($urandom_range(7, 0)), int'($urandom_range(255, 0)),
            int'($urandom_range(255, 0)), int'($urandom_range(1, 0)));
    end

    // Reset asserted between edges must clear outputs without a clock.
    do_op("pre_reset", 0, 8'h12, 8'h34, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_async", {out, out_flags}, 12'h000);
    @(posedge clock);
    #1;
    check("reset_held", {out, out_flags}, 12'h000);
    @(negedge clock);
    reset_n = 1'b1;
    alu_op = 3'd6; in_A = 8'h5C; in_B = 8'hF0; in_C = 1'b0;
    #1;
    check("post_reset_latency", {out, out_flags}, 12'h000);
    @(posedge clock);
    #1;
    check("post_reset_first", {out, out_flags}, model(6, 8'h5C, 8'hF0, 0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
